// File: rtl/rc5_round_scheduler_pkg.sv
// Shared types, defaults and rotate helpers for the RC5 round scheduler.
// The rotate helpers are fixed at the default 32-bit half-block width.
package rc5_round_scheduler_pkg;

    localparam int ROUNDS_DEF = 12;
    localparam int W_DEF      = 32;
    localparam int SKEY_WORDS = 26;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ROUND = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_PRE   = 2'd0,
        PH_ROUND = 2'd1,
        PH_POST  = 2'd2
    } phase_t;

    // A zero amount returns the operand untouched rather than relying on a shift by 32.
    function automatic logic [W_DEF-1:0] rotl(input logic [W_DEF-1:0] x, input logic [4:0] n);
        if (n == 5'd0)
            return x;
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [W_DEF-1:0] rotr(input logic [W_DEF-1:0] x, input logic [4:0] n);
        if (n == 5'd0)
            return x;
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/rc5_round_unit.sv
// Combinational RC5 step: key whitening, one full round, or un-whitening,
// in either direction. Shared by both requesters.
module rc5_round_unit
    import rc5_round_scheduler_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         dec,
    input  phase_t       phase,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s_even,
    input  logic [W-1:0] s_odd,
    output logic [W-1:0] a_next,
    output logic [W-1:0] b_next
);

    logic [W-1:0] a_mid;
    logic [W-1:0] b_mid;

    always_comb begin
        a_next = a;
        b_next = b;
        a_mid  = '0;
        b_mid  = '0;
        case (phase)
            PH_PRE: begin
                if (!dec) begin
                    a_next = a + s_even;
                    b_next = b + s_odd;
                end
            end
            PH_ROUND: begin
                if (!dec) begin
                    a_mid  = rotl(a ^ b, b[4:0]) + s_even;
                    a_next = a_mid;
                    b_next = rotl(b ^ a_mid, a_mid[4:0]) + s_odd;
                end else begin
                    // Inverse order: B is undone first, using the still-encrypted A.
                    b_mid  = rotr(b - s_odd, a[4:0]) ^ a;
                    b_next = b_mid;
                    a_next = rotr(a - s_even, b_mid[4:0]) ^ b_mid;
                end
            end
            PH_POST: begin
                if (dec) begin
                    a_next = a - s_even;
                    b_next = b - s_odd;
                end
            end
            default: begin
                a_next = a;
                b_next = b;
            end
        endcase
    end

endmodule

// File: rtl/rc5_round_scheduler.sv
// Iterative RC5 engine time-shared between an encrypt and a decrypt requester,
// with round-robin arbitration and a held result until the consumer takes it.
module rc5_round_scheduler
    import rc5_round_scheduler_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int W      = W_DEF
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [(2*ROUNDS+2)*W-1:0]  skey,
    input  logic                       enc_vld,
    input  logic [2*W-1:0]             enc_din,
    output logic                       enc_rdy,
    input  logic                       dec_vld,
    input  logic [2*W-1:0]             dec_din,
    output logic                       dec_rdy,
    output logic [2*W-1:0]             dout,
    output logic                       dout_dec,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic                       busy
);

    localparam int          NWORDS     = 2 * ROUNDS + 2;
    localparam logic [3:0]  ROUNDS_CNT = 4'(ROUNDS);

    state_t       state_reg;
    logic [3:0]   cnt_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic         dec_reg;
    logic         prio_enc_reg;
    logic         idle;
    logic [3:0]   pair_idx;
    phase_t       phase;
    logic [W-1:0] s_even;
    logic [W-1:0] s_odd;
    logic [W-1:0] a_next;
    logic [W-1:0] b_next;
    logic [W-1:0] skey_w [NWORDS];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_skey
            assign skey_w[gi] = skey[gi*W +: W];
        end
    endgenerate

    // Whitening steps use S0/S1; rounds use the pair selected by the counter.
    assign pair_idx = (state_reg == ST_ROUND) ? cnt_reg : 4'd0;
    assign s_even   = skey_w[{pair_idx, 1'b0}];
    assign s_odd    = skey_w[{pair_idx, 1'b1}];
    assign phase    = (state_reg == ST_PRE)   ? PH_PRE :
                      (state_reg == ST_ROUND) ? PH_ROUND : PH_POST;

    assign idle    = (state_reg == ST_IDLE);
    assign enc_rdy = idle && enc_vld && (prio_enc_reg || !dec_vld);
    assign dec_rdy = idle && dec_vld && (!prio_enc_reg || !enc_vld);
    assign busy    = !idle;

    rc5_round_unit #(.W(W)) u_round (
        .dec    (dec_reg),
        .phase  (phase),
        .a      (a_reg),
        .b      (b_reg),
        .s_even (s_even),
        .s_odd  (s_odd),
        .a_next (a_next),
        .b_next (b_next)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            a_reg        <= '0;
            b_reg        <= '0;
            dec_reg      <= 1'b0;
            prio_enc_reg <= 1'b1;
            dout         <= '0;
            dout_dec     <= 1'b0;
            dout_vld     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enc_rdy) begin
                        a_reg        <= enc_din[2*W-1:W];
                        b_reg        <= enc_din[W-1:0];
                        dec_reg      <= 1'b0;
                        prio_enc_reg <= 1'b0;
                        state_reg    <= ST_PRE;
                    end else if (dec_rdy) begin
                        a_reg        <= dec_din[2*W-1:W];
                        b_reg        <= dec_din[W-1:0];
                        dec_reg      <= 1'b1;
                        prio_enc_reg <= 1'b1;
                        state_reg    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    cnt_reg   <= dec_reg ? ROUNDS_CNT : 4'd1;
                    state_reg <= ST_ROUND;
                end
                ST_ROUND: begin
                    a_reg <= a_next;
                    b_reg <= b_next;
                    if (dec_reg ? (cnt_reg == 4'd1) : (cnt_reg == ROUNDS_CNT)) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= ST_POST;
                    end else begin
                        cnt_reg <= dec_reg ? cnt_reg - 4'd1 : cnt_reg + 4'd1;
                    end
                end
                ST_POST: begin
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    if (!dout_vld) begin
                        dout     <= {a_reg, b_reg};
                        dout_dec <= dec_reg;
                        dout_vld <= 1'b1;
                    end else if (dout_rdy) begin
                        dout_vld  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rc5_round_scheduler.md
RC5_ROUND_SCHEDULER -- requirements
Module: rc5_round_scheduler

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 12, giving the number of RC5 rounds (key table holds 2*ROUNDS+2 words).
REQ-002 The block SHALL have parameter W, default 32, giving the RC5 half-block width in bits.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port clr, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port skey, input, 832 bits: expanded key table; word k occupies bits [32k+31:32k], k=0..25.
REQ-006 Port enc_vld, input, 1 bit: encrypt requester has a block.
REQ-007 Port enc_din, input, 64 bits: encrypt block, A=[63:32], B=[31:0].
REQ-008 Port enc_rdy, output, 1 bit: encrypt request accepted when enc_vld&&enc_rdy.
REQ-009 Port dec_vld, input, 1 bit: decrypt requester has a block.
REQ-010 Port dec_din, input, 64 bits: decrypt block, same A/B packing as enc_din.
REQ-011 Port dec_rdy, output, 1 bit: decrypt request accepted when dec_vld&&dec_rdy.
REQ-012 Port dout, output, 64 bits: result block {A,B}.
REQ-013 Port dout_dec, output, 1 bit: 1 when dout is a decrypt result.
REQ-014 Port dout_vld, output, 1 bit: result valid.
REQ-015 Port dout_rdy, input, 1 bit: consumer accepts the result when dout_vld&&dout_rdy.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The block SHALL time-share one iterative round unit between the encrypt and decrypt requesters, one round per cycle.
REQ-018 The FSM SHALL have states IDLE, PRE, ROUND, POST and DONE.
- IDLE->PRE on acceptance; PRE->ROUND after one cycle.
- ROUND holds for ROUNDS cycles, then ->POST; POST->DONE after one cycle.
- DONE->IDLE on dout_vld&&dout_rdy.
REQ-019 enc_rdy and dec_rdy SHALL be high only in IDLE, and at most one SHALL be high in any cycle.
REQ-020 When only one requester is valid in IDLE, it SHALL be granted; when both are valid, the requester not granted last SHALL win (round-robin); the priority pointer SHALL reset to favour encrypt.
REQ-021 Encrypt datapath:
- PRE: A+=S0, B+=S1.
- Round i=1..12: A=rotl(A^B,B[4:0])+S[2i]; B=rotl(B^A,A[4:0])+S[2i+1].
- POST: pass-through.
REQ-022 Decrypt datapath:
- PRE: pass-through.
- Round i=12..1: B=rotr(B-S[2i+1],A[4:0])^A; A=rotr(A-S[2i],B[4:0])^B.
- POST: B-=S1, A-=S0.
REQ-023 All arithmetic SHALL be modulo 2^32; a rotate amount of 0 SHALL return the operand unchanged (no shift-by-32).
REQ-024 The round counter SHALL be 4 bits: it counts up 1..12 for encrypt and down 12..1 for decrypt, and selects the S-word pair.
REQ-025 dout_vld SHALL rise on the 15th rising edge after the accepting edge and hold with dout/dout_dec stable until accepted.
REQ-026 A request arriving in the cycle dout is accepted SHALL NOT be granted until the following IDLE cycle.
REQ-027 skey SHALL be held stable by the integrator while busy; the block SHALL NOT register skey.

Reset
REQ-028 When clr is low, the FSM SHALL go to IDLE, and dout, dout_dec, dout_vld, busy, the round counter and the A/B registers SHALL be cleared to 0, irrespective of clk.
REQ-029 Assertion of clr mid-operation SHALL abort the block without emitting a result; the first request after release SHALL complete normally.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, ROUNDS/W defaults, the SKEY_WORDS=26 constant and the rotl/rotr functions.
REQ-031 The single half-round datapath SHALL be one sub-module, rc5_round_unit (combinational, mode input enc/dec), instantiated once.

Verification
REQ-032 Round-trip: with a fixed nonzero skey, encrypt 64'h0123456789ABCDEF, then decrypt the result -> the decrypt dout equals 64'h0123456789ABCDEF with dout_dec=1.
REQ-033 Golden model: 100 random blocks/keys per mode -> dout matches the software RC5-32/12 model, with dout_vld exactly 15 edges after acceptance.
REQ-034 Contention: enc_vld and dec_vld held high for 4 jobs -> grants alternate enc, dec, enc, dec, and never both rdy at once.
REQ-035 Backpressure: dout_rdy=0 for 10 cycles in DONE -> dout_vld, dout and dout_dec remain stable, busy=1, and no rdy is asserted.
REQ-036 Reset mid-ROUND (counter=6): clr low -> all outputs 0 immediately; after release, a new request produces the correct result.
REQ-037 Zero rotate: operands giving rotate amount 0 (A=B=0, skey all 0) -> encrypt dout equals 64'h0.
